pgm_gfx_ddr_bridge: RTL and testbench

Read bridge between the PGM video engine's graphics-fetch port and the MiSTer DDR3 Avalon-MM read port. It converts single 64-bit word requests into aligned bursts and holds the most recent burst in a one-line buffer, so sequential sprite-pixel fetches hit locally. It returns data with a one-cycle `dout_ready` pulse, matching the video engine's request/ready handshake.

---
 rtl/pgm_gfx_ddr_bridge_if.sv | 32 +++
 rtl/pgm_gfx_ddr_bridge.sv | 181 ++++++++++++++++++
 tb/tb_pgm_gfx_ddr_bridge.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_gfx_ddr_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : pgm_gfx_ddr_bridge_if
// Brief    : Graphics-fetch client port plus Avalon-MM read port bundle.
// Revision : 1.0
// ============================================================================
interface pgm_gfx_ddr_bridge_if;
    logic        rd;
    logic [28:0] addr;
    logic [63:0] dout;
    logic        busy;
    logic        dout_ready;
    logic        inval;
    logic        ddr_rd;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic        ddr_waitrequest;
    logic [63:0] ddr_dout;
    logic        ddr_dout_ready;

    // The bridge is the slave; the video engine plus DDR controller form the master side.
    modport slave (
        input  rd, addr, inval, ddr_waitrequest, ddr_dout, ddr_dout_ready,
        output dout, busy, dout_ready, ddr_rd, ddr_addr, ddr_burstcnt
    );

    modport master (
        output rd, addr, inval, ddr_waitrequest, ddr_dout, ddr_dout_ready,
        input  dout, busy, dout_ready, ddr_rd, ddr_addr, ddr_burstcnt
    );
endinterface
`default_nettype wire

// File: rtl/pgm_gfx_ddr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : pgm_gfx_ddr_bridge
// Brief    : 64-bit word reads turned into aligned DDR bursts, one-line buffer.
// Revision : 1.0
// ============================================================================
module pgm_gfx_ddr_bridge #(
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pgm_gfx_ddr_bridge_if.slave  bus
);
    localparam int OFFW  = $clog2(BURST);
    localparam int TAGW  = 29 - OFFW;
    localparam int PENDW = OFFW + 1;
    localparam logic [PENDW-1:0] PEND_FULL = PENDW'(BURST);
    localparam logic [OFFW-1:0]  LAST_BEAT = OFFW'(BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIT   = 3'd1,
        S_REQ   = 3'd2,
        S_FILL  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [63:0]      line_buf [BURST];
    logic [TAGW-1:0]  tag, tag_nxt;
    logic             valid, valid_nxt;
    logic             armed, armed_nxt;
    logic             fill_inval, fill_inval_nxt;
    logic [28:0]      req_addr, req_addr_nxt;
    logic [OFFW-1:0]  beat, beat_nxt;
    logic [PENDW-1:0] pend, pend_nxt;
    logic             ddr_rd_q, ddr_rd_nxt;
    logic [28:0]      ddr_addr_q, ddr_addr_nxt;
    logic [63:0]      dout_q, dout_nxt;
    logic             dout_ready_q, dout_ready_nxt;
    logic             buf_we;
    logic [OFFW-1:0]  req_off;
    logic             accept;
    logic             tag_hit;
    logic             grant;

    assign req_off = req_addr[OFFW-1:0];
    assign grant   = ddr_rd_q && !bus.ddr_waitrequest;
    assign accept  = bus.rd && (state == S_IDLE) && armed;
    assign tag_hit = valid && !bus.inval && (tag == bus.addr[28:OFFW]);

    // Outstanding beats of a granted burst; an Avalon burst cannot be aborted, so no reset.
    always_comb begin
        pend_nxt = pend;
        if (grant)
            pend_nxt = PEND_FULL;
        else if (bus.ddr_dout_ready && (pend != '0))
            pend_nxt = pend - PENDW'(1);
    end

    always_ff @(posedge clk) begin
        pend <= pend_nxt;
    end

    always_comb begin
        state_nxt      = state;
        tag_nxt        = tag;
        valid_nxt      = valid;
        armed_nxt      = armed;
        fill_inval_nxt = fill_inval;
        req_addr_nxt   = req_addr;
        beat_nxt       = beat;
        ddr_rd_nxt     = ddr_rd_q;
        ddr_addr_nxt   = ddr_addr_q;
        dout_nxt       = dout_q;
        dout_ready_nxt = 1'b0;
        buf_we         = 1'b0;

        if (!bus.rd)
            armed_nxt = 1'b1;
        if (bus.inval)
            fill_inval_nxt = 1'b1;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_addr_nxt = bus.addr;
                    if (tag_hit) begin
                        state_nxt = S_HIT;
                    end else begin
                        valid_nxt      = 1'b0;
                        fill_inval_nxt = 1'b0;
                        ddr_addr_nxt   = {bus.addr[28:OFFW], {OFFW{1'b0}}};
                        ddr_rd_nxt     = 1'b1;
                        state_nxt      = S_REQ;
                    end
                end
            end
            S_HIT: begin
                dout_nxt       = line_buf[req_off];
                dout_ready_nxt = 1'b1;
                state_nxt      = S_IDLE;
            end
            S_REQ: begin
                if (!bus.ddr_waitrequest) begin
                    ddr_rd_nxt = 1'b0;
                    beat_nxt   = '0;
                    state_nxt  = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.ddr_dout_ready) begin
                    buf_we   = 1'b1;
                    beat_nxt = beat + OFFW'(1);
                    if (beat == req_off) begin
                        dout_nxt       = bus.ddr_dout;
                        dout_ready_nxt = 1'b1;
                    end
                    if (beat == LAST_BEAT) begin
                        // An invalidate seen during the fetch means the line may be stale.
                        tag_nxt   = req_addr[28:OFFW];
                        valid_nxt = !(fill_inval || bus.inval);
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (pend == '0)
                    state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The client still holds rd during its ready cycle; disarm so it is not re-accepted.
        if (dout_ready_nxt)
            armed_nxt = 1'b0;
        if (bus.inval)
            valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= (pend_nxt != '0) ? S_DRAIN : S_IDLE;
            valid        <= 1'b0;
            beat         <= '0;
            armed        <= 1'b1;
            fill_inval   <= 1'b0;
            ddr_rd_q     <= 1'b0;
            ddr_addr_q   <= '0;
            dout_q       <= '0;
            dout_ready_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            tag          <= tag_nxt;
            valid        <= valid_nxt;
            beat         <= beat_nxt;
            armed        <= armed_nxt;
            fill_inval   <= fill_inval_nxt;
            req_addr     <= req_addr_nxt;
            ddr_rd_q     <= ddr_rd_nxt;
            ddr_addr_q   <= ddr_addr_nxt;
            dout_q       <= dout_nxt;
            dout_ready_q <= dout_ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            line_buf[beat] <= bus.ddr_dout;
    end

    assign bus.dout         = dout_q;
    assign bus.dout_ready   = dout_ready_q;
    assign bus.ddr_rd       = ddr_rd_q;
    assign bus.ddr_addr     = ddr_addr_q;
    assign bus.ddr_burstcnt = 8'(BURST);
    assign bus.busy         = (state != S_IDLE) || (!armed && bus.rd);
endmodule
`default_nettype wire

// File: tb/tb_pgm_gfx_ddr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgm_gfx_ddr_bridge
// Brief    : Randomized scoreboard bench for the graphics-fetch DDR bridge.
// Revision : 1.0
// ============================================================================
module tb_pgm_gfx_ddr_bridge;
    localparam int BURST = 4;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    pgm_gfx_ddr_bridge_if bus();

    pgm_gfx_ddr_bridge #(.BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    logic [28:0] ddr_exp_q[$];
    logic [28:0] burst_q[$];
    int          beat_idx = 0;
    int          beats_total = 0;
    int          grants = 0;
    int          stop_after = -1;
    int          wr_hold = 0;
    bit          hold_first = 1'b0;
    logic [28:0] hold_addr = '0;
    int          gen = 0;
    logic [28:0] cur_addr = '0;
    int          match_cyc = -1;
    bit          mvalid = 1'b0;
    logic [28:0] mline = '0;

    // Backing ROM contents; gen changes whenever the ROM is "re-downloaded".
    function automatic logic [63:0] mem(input logic [28:0] a);
        return {gen[7:0], 3'b000, a, a[23:0] ^ 24'hA55A3C};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every dout_ready pops one expected word.
    always @(negedge clk) begin
        if (bus.dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_ready: got dout_ready=1 (dout %h) expected 0", bus.dout);
            end else begin
                check("dout", bus.dout, exp_q.pop_front());
            end
        end
    end

    // DDR model: beats first so a burst never returns data in its own grant cycle.
    always @(negedge clk) begin
        bus.ddr_dout_ready = 1'b0;
        if (burst_q.size() != 0 && beat_idx != stop_after && $urandom_range(0, 3) != 0) begin
            bus.ddr_dout       = mem(burst_q[0] + 29'(beat_idx));
            bus.ddr_dout_ready = 1'b1;
            if (burst_q[0] + 29'(beat_idx) == cur_addr)
                match_cyc = cyc;
            beat_idx++;
            beats_total++;
            if (beat_idx == BURST) begin
                void'(burst_q.pop_front());
                beat_idx = 0;
            end
        end
        if (bus.ddr_rd === 1'b1) begin
            if (wr_hold > 0) begin
                if (hold_first) begin
                    hold_addr  = bus.ddr_addr;
                    hold_first = 1'b0;
                end else begin
                    check("stall_addr_stable", bus.ddr_addr, hold_addr);
                end
                wr_hold--;
                bus.ddr_waitrequest = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.ddr_waitrequest = 1'b1;
            end else begin
                bus.ddr_waitrequest = 1'b0;
                grants++;
                check("burstcnt", bus.ddr_burstcnt, BURST);
                if (ddr_exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got ddr_addr %h expected no burst", bus.ddr_addr);
                end else begin
                    check("ddr_addr", bus.ddr_addr, ddr_exp_q.pop_front());
                end
                burst_q.push_back(bus.ddr_addr);
            end
        end else begin
            bus.ddr_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        while (bus.busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic do_read(input logic [28:0] a, input int hold, input bit inv_fill);
        bit exp_hit;
        int g0, b0, waited;
        bit inv_done;
        wait_idle();
        exp_hit = mvalid && (mline == 29'(a / BURST));
        exp_q.push_back(mem(a));
        if (!exp_hit)
            ddr_exp_q.push_back(29'(a - a % BURST));
        g0        = grants;
        b0        = beats_total;
        inv_done  = 1'b0;
        cur_addr  = a;
        match_cyc = -1;
        bus.rd    = 1'b1;
        bus.addr  = a;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited == 1) begin
                check("ddr_rd_after_accept", bus.ddr_rd, !exp_hit);
                bus.addr = 29'($urandom);
            end
            if (bus.inval)
                bus.inval = 1'b0;
            if (inv_fill && !inv_done && beats_total > b0) begin
                bus.inval = 1'b1;
                inv_done  = 1'b1;
            end
        end while (bus.dout_ready !== 1'b1 && waited < 400);
        bus.inval = 1'b0;
        if (bus.dout_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got no dout_ready for addr %h expected one", a);
            exp_q.delete();
        end else begin
            if (exp_hit)
                check("hit_latency", waited, 2);
            else
                check("miss_ready_timing", cyc, match_cyc + 1);
            check("bursts_issued", grants - g0, exp_hit ? 0 : 1);
            check("busy_at_ready", bus.busy, 1);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("busy_while_held", bus.busy, 1);
        end
        bus.rd = 1'b0;
        @(negedge clk);
        if (!exp_hit) begin
            mline  = 29'(a / BURST);
            mvalid = !inv_fill;
        end
    endtask

    task automatic pulse_inval();
        bus.inval = 1'b1;
        @(negedge clk);
        bus.inval = 1'b0;
        gen++;
        mvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, b0;
        logic [28:0] a, prev;
        bus.rd    = 1'b0;
        bus.addr  = '0;
        bus.inval = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout_ready", bus.dout_ready, 0);
        check("rst_ddr_rd", bus.ddr_rd, 0);
        check("rst_ddr_addr", bus.ddr_addr, 0);
        check("rst_burstcnt", bus.ddr_burstcnt, BURST);
        check("rst_dout", bus.dout, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss then sequential hits in the same line.
        do_read(29'h0000105, 0, 1'b0);
        do_read(29'h0000106, 0, 1'b0);
        do_read(29'h0000107, 0, 1'b0);
        // Client keeps rd high past its ready cycle.
        do_read(29'h0000104, 3, 1'b0);

        // Long waitrequest stall on a miss.
        hold_first = 1'b1;
        wr_hold    = 5;
        do_read(29'h0000209, 0, 1'b0);
        check("stall_consumed", wr_hold, 0);

        // Invalidate during the fill: word delivered, line not retained.
        do_read(29'h000030B, 0, 1'b1);
        do_read(29'h000030A, 0, 1'b0);

        // Reset in the middle of a burst drains the remaining beats.
        wait_idle();
        @(negedge clk);
        ddr_exp_q.push_back(29'h0000400);
        cur_addr   = 29'h0000403;
        stop_after = 2;
        b0         = beats_total;
        bus.rd     = 1'b1;
        bus.addr   = 29'h0000403;
        w = 0;
        while (beats_total < b0 + 2 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reset_setup_beats", beats_total - b0, 2);
        reset  = 1'b1;
        bus.rd = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        stop_after = -1;
        check("drain_busy", bus.busy, 1);
        check("drain_no_ready", bus.dout_ready, 0);
        w = 0;
        while (burst_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
            check("drain_busy_hold", bus.busy, 1);
        end
        repeat (2) @(negedge clk);
        check("drain_done", bus.busy, 0);
        mvalid = 1'b0;
        do_read(29'h0000401, 0, 1'b0);

        // Randomized traffic over a handful of lines plus the top of memory.
        prev = 29'h0000800;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 29'h1FFFFFFC + 29'($urandom_range(0, 3));
                1, 2, 3: a = 29'(prev - prev % BURST) + 29'($urandom_range(0, BURST - 1));
                default: a = 29'h0000800 + 29'($urandom_range(0, 6 * BURST - 1));
            endcase
            do_read(a, $urandom_range(0, 2), 1'b0);
            prev = a;
            if ($urandom_range(0, 9) == 0)
                pulse_inval();
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
